// File: rtl/hex_display_sequencer.sv
// hex_display_sequencer: Avalon-MM master that decodes a packed hex value and writes one
// active-low seven-segment code per HEX PIO slave. Define HEX_BLANK_LZ_EN for leading-zero blanking.

module hex_seg_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    // bit6=g ... bit0=a, 0 = segment lit
    always_comb begin
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end
endmodule

module hex_display_sequencer #(
    parameter int          NUM_DIGITS  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] ADDR_STRIDE = 32'd16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] in_value,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [31:0]             m_address,
    output logic                    m_write,
    output logic [31:0]             m_writedata,
    input  logic                    m_waitrequest,
    output logic                    busy,
    output logic                    done
);
    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    typedef struct packed {
        logic [31:0] address;
        logic [6:0]  seg;
    } wr_cmd_t;

    state_t                     state, state_nxt;
    logic [IDX_W-1:0]           idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0]    value_q, value_nxt;
    logic [NUM_DIGITS-1:0][6:0] seg_raw, seg_lane;
    wr_cmd_t                    cmd;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
        hex_seg_decode u_dec (
            .nibble (value_q[4*g +: 4]),
            .seg    (seg_raw[g])
        );
    end

`ifdef HEX_BLANK_LZ_EN
    logic [NUM_DIGITS-1:0] blank;

    // Scan from the top nibble down; a digit is blank until the first non-zero nibble is seen.
    always_comb begin
        logic nz;
        nz    = 1'b0;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz       = nz | (value_q[4*i +: 4] != 4'h0);
            blank[i] = (i != 0) && !nz;
        end
    end

    always_comb begin
        seg_lane = seg_raw;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (blank[i]) seg_lane[i] = 7'h7F;
    end
`else
    assign seg_lane = seg_raw;
`endif

    // Command depends only on registered state, so it holds steady through any stall.
    always_comb begin
        cmd = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx == IDX_W'(i)) cmd.seg = seg_lane[i];
        cmd.address = BASE_ADDR + 32'(idx) * ADDR_STRIDE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            value_q <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            value_q <= value_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        value_nxt   = value_q;
        in_ready    = 1'b0;
        m_write     = 1'b0;
        m_address   = '0;
        m_writedata = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    value_nxt = in_value;
                    idx_nxt   = '0;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                m_write     = 1'b1;
                busy        = 1'b1;
                m_address   = cmd.address;
                m_writedata = {25'b0, cmd.seg};
                if (!m_waitrequest) begin
                    if (idx == LAST_IDX) state_nxt = DONE;
                    else                 idx_nxt   = idx + IDX_W'(1);
                end
            end
            DONE: begin
                done     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    value_nxt = in_value;
                    idx_nxt   = '0;
                    state_nxt = WRITE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
